// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO enqueue arbiter: FSM encoding and default word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_arb_pkg;

    // Arbiter FSM: S_IDLE picks the next requester, S_BURST forwards its words.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } arb_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fifo_enqueue_arbiter_if.sv
// Producer-side and FIFO-side bundle of the enqueue arbiter.
// Latency: n/a (wires only).
// Backpressure: fifo_full from the FIFO, per-word ack back to the producers.
//
// Signals:
//   req             producers -> arbiter  per-requester word-valid level
//   data            producers -> arbiter  flattened words, requester i at [i*WIDTH +: WIDTH]
//   ack             arbiter -> producers  one-hot/zero, word enqueued this cycle
//   fifo_full       FIFO -> arbiter       FIFO is_full
//   enqueue_request arbiter -> FIFO       push strobe
//   enqueue_data    arbiter -> FIFO       pushed word
//   enqueue_source  arbiter -> FIFO       index of the granted requester
//
// master = environment side (producers + FIFO), slave = arbiter side.
interface fifo_enqueue_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   data;
    logic [NREQ-1:0]         ack;
    logic                    fifo_full;
    logic                    enqueue_request;
    logic [WIDTH-1:0]        enqueue_data;
    logic [$clog2(NREQ)-1:0] enqueue_source;

    modport master (
        output req, data, fifo_full,
        input  ack, enqueue_request, enqueue_data, enqueue_source
    );

    modport slave (
        input  req, data, fifo_full,
        output ack, enqueue_request, enqueue_data, enqueue_source
    );

endinterface

// File: rtl/fifo_enqueue_arbiter_rr_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   req  in   NREQ           request vector
//   ptr  in   $clog2(NREQ)   search start index (always < NREQ)
//   vld  out  1              some request bit is set
//   idx  out  $clog2(NREQ)   chosen requester, 0 when !vld
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    vld,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    // Walk offsets from far to near so the nearest set bit after ptr is the
    // last one written. The modulo keeps non-power-of-2 indices in range.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int unsigned j;
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_enqueue_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among NREQ producers, bursts of up to MAX_BURST words.
// Latency: first ack one cycle after req is seen in idle; one idle bubble between grants.
// Backpressure: fifo_full stalls the granted requester (ack=0) without releasing the grant.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    fifo_enqueue_arbiter_if.slave (req/data/ack producer side, fifo_full/enqueue_* FIFO side)
module fifo_enqueue_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    fifo_enqueue_arbiter_if.slave         bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   grant_idx_q, grant_idx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            grant_req;
    logic            fire;
    logic [IW-1:0]   grant_next;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign grant_req  = bus.req[grant_idx_q];
    assign grant_next = (grant_idx_q == IW'(NREQ - 1)) ? '0 : grant_idx_q + 1'b1;

    // Gating with reset keeps every output quiet in the reset cycle even if
    // the FSM was mid-burst when reset arrived.
    assign fire = (state_q == S_BURST) && grant_req && !bus.fifo_full && !reset;

    always_comb begin
        bus.ack             = '0;
        bus.enqueue_request = fire;
        bus.enqueue_data    = '0;
        bus.enqueue_source  = '0;
        if (fire) begin
            bus.ack[grant_idx_q] = 1'b1;
            bus.enqueue_data     = bus.data[grant_idx_q*WIDTH +: WIDTH];
        end
        if ((state_q == S_BURST) && !reset) begin
            bus.enqueue_source = grant_idx_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_idx_d = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                if (!grant_req) begin
                    // Requester went away (with or without sending): rotate.
                    rr_ptr_d = grant_next;
                    state_d  = S_IDLE;
                end else if (!bus.fifo_full) begin
                    if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
                        rr_ptr_d = grant_next;
                        state_d  = S_IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
                // req held with FIFO full: everything holds.
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
